// File: rtl/seq_divider.sv
// seq_divider: restoring divider, one quotient bit per clock.
// Define SEQ_DIVIDER_SIGNED_EN to honour the sign input.
module seq_divider #(
  parameter int WORD = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            sign,
  input  logic [WORD-1:0] a,
  input  logic [WORD-1:0] b,
  output logic            ready,
  output logic            valid,
  output logic [WORD-1:0] quotient,
  output logic [WORD-1:0] remainder,
  output logic            div_zero
);

  localparam int CW = $clog2(WORD + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [WORD-1:0] pr_q;
  logic [WORD-1:0] dq_q;
  logic [WORD-1:0] dv_q;
  logic [CW-1:0]   cnt_q;

  logic [WORD:0]   sh;
  logic [WORD+1:0] diff;
  logic            fit;
  logic [WORD-1:0] pr_n;
  logic [WORD-1:0] dq_n;
  logic [WORD-1:0] a_mag;
  logic [WORD-1:0] b_mag;
  logic [WORD-1:0] q_fin;
  logic [WORD-1:0] r_fin;
  logic            accept;
  logic            b_zero;
  logic            last;

  assign ready  = (state_q == IDLE);
  assign valid  = (state_q == DONE);
  assign accept = ready && start;
  assign b_zero = (b == '0);
  assign last   = (cnt_q == CW'(1));

  // Partial remainder never exceeds the divisor, so WORD+1 bits
  // of shifted value and one extra borrow bit are enough.
  always_comb begin
    sh   = {pr_q, dq_q[WORD-1]};
    diff = {1'b0, sh} - {2'b00, dv_q};
    fit  = ~diff[WORD+1];
    pr_n = fit ? diff[WORD-1:0] : sh[WORD-1:0];
    dq_n = {dq_q[WORD-2:0], fit};
  end

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_q_q;
  logic neg_r_q;
  logic a_neg;
  logic b_neg;

  assign a_neg = sign && a[WORD-1];
  assign b_neg = sign && b[WORD-1];

  always_comb begin
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
    q_fin = neg_q_q ? -dq_n : dq_n;
    r_fin = neg_r_q ? -pr_n : pr_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else if (accept) begin
      neg_q_q <= a_neg ^ b_neg;
      neg_r_q <= a_neg;
    end
  end
`else
  logic unused_sign;
  assign unused_sign = sign;

  always_comb begin
    a_mag = a;
    b_mag = b;
    q_fin = dq_n;
    r_fin = pr_n;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = b_zero ? DONE : CALC;
        end
      end
      CALC: begin
        if (last) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Results load on the edge entering DONE, so they are
  // already stable while valid is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pr_q      <= '0;
      dq_q      <= '0;
      dv_q      <= '0;
      cnt_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else if (accept) begin
      pr_q  <= '0;
      dq_q  <= a_mag;
      dv_q  <= b_mag;
      cnt_q <= CW'(WORD);
      if (b_zero) begin
        quotient  <= '1;
        remainder <= a;
        div_zero  <= 1'b1;
      end
    end else if (state_q == CALC) begin
      pr_q  <= pr_n;
      dq_q  <= dq_n;
      cnt_q <= cnt_q - CW'(1);
      if (last) begin
        quotient  <= q_fin;
        remainder <= r_fin;
        div_zero  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle iterative divider; the inverse partner of the single-cycle ALU multiply path.
- Takes division/modulo off the combinational ALU critical path.
- Computes quotient and remainder together using restoring division, one bit per clock.
- Sits beside the ALU in the execute stage; the control unit stalls on `ready`/`valid`.

Parameters:
- WORD, 8, operand/result width in bits (>= 2)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only when ready=1
- sign  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- a  input  WORD  dividend; sampled with start
- b  input  WORD  divisor; sampled with start
- ready  output  1  idle, can accept start
- valid  output  1  one-cycle pulse, result outputs updated
- quotient  output  WORD  a / b, truncated toward zero
- remainder  output  WORD  a % b, carries the sign of the dividend
- div_zero  output  1  last result came from b == 0

Behaviour:
- One clock domain.
- Reset is asynchronous and active-high: asserting `rst` forces the following immediately, regardless of clk:
  - state=IDLE
  - ready=1, valid=0
  - quotient=0, remainder=0, div_zero=0
  - internal registers cleared
- Reset mid-operation aborts the operation with no valid pulse.
- States:
  - IDLE: ready=1. On start=1, latch a, b, sign.
    - If b==0: go to DONE.
    - Otherwise: take magnitudes of a and b (when sign=1), record neg_q = a[MSB]^b[MSB] and neg_r = a[MSB], clear the partial remainder, set count=WORD, go to CALC.
  - CALC: ready=0. Each cycle:
    - Shift {partial remainder, dividend register} left by 1.
    - Trial-subtract the divisor magnitude; if the result is non-negative, keep it and shift in quotient bit 1, else shift in 0.
    - Decrement count; on the cycle count reaches 0, go to DONE.
  - DONE: ready=0. Register the final outputs, valid=1 for exactly this cycle, next state IDLE.
- Latency: start accepted at cycle 0 -> valid at cycle WORD+1. Divide-by-zero -> valid at cycle 1.
- Final result:
  - quotient = neg_q ? -q_mag : q_mag.
  - remainder = neg_r ? -r_mag : r_mag.
  - Negation is modulo 2^WORD.
- Divide by zero: quotient = all ones, remainder = a (raw), div_zero=1. For all other results div_zero=0.
- Signed overflow (most-negative / -1): quotient = most-negative (wraps), remainder = 0. No flag is raised.
- `start` while ready=0 is ignored; no queueing.
- `start` in the same cycle that DONE returns to IDLE is not accepted, because ready=0 in DONE.
- Back-to-back operation: start is accepted on the first IDLE cycle after a valid pulse.
- Result outputs hold their last value until the next valid pulse. They do not change during CALC.
- Operand inputs are don't-care except in the cycle where start is accepted.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN
- Defined:
  - `sign` input is honoured as described above.
- Undefined:
  - `sign` is ignored and all operands are treated as unsigned.
  - Magnitude/negation logic is not synthesised.
  - Remainder is always the unsigned remainder.
  - The divide-by-zero and latency rules are unchanged.

Test Plan:
- Reset, then a=64, b=4, sign=0, start -> after 9 cycles: valid=1, quotient=16, remainder=0, div_zero=0, ready=1 on the next cycle.
- a=65, b=4, sign=0 -> quotient=16, remainder=1. Then a=200, b=7 -> quotient=28, remainder=4.
- Signed (macro defined):
  - a=64, b=-4 -> quotient=8'hF0 (-16), remainder=0.
  - a=-7, b=2 -> quotient=-3, remainder=-1.
  - a=-128, b=-1 -> quotient=8'h80, remainder=0.
  - Macro undefined, a=8'hF9, b=2, sign=1 -> quotient=124, remainder=1.
- a=37, b=0 -> valid at cycle 1, quotient=8'hFF, remainder=37, div_zero=1. The next normal divide clears div_zero.
- start during cycle 4 of CALC with different operands -> ignored; the original result is delivered at cycle 9 with exactly one valid pulse.
- Assert rst at cycle 5 of CALC -> ready=1, valid=0, outputs 0 with no clock edge; no valid pulse follows. A new start after reset completes normally.
